// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO and a programmable baud divisor.
// Define UART_PARITY_EN to add an even-parity bit after the data bits.
module uart_tx_mmio #(
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        write_en,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        hit,
   output logic        tx
);

   localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_PARITY_EN
   localparam logic PARITY_FEATURE = 1'b1;
`else
   localparam logic PARITY_FEATURE = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t          state;
   logic [7:0]      fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic [15:0]     divisor, div_lat, baud_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            overflow;
`ifdef UART_PARITY_EN
   logic            par_bit;
`endif

   logic [1:0] offset;
   logic       wr_sel, push_req, push_ok, pop, full, empty, busy, last_baud;

   assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
   assign offset    = addr[3:2];
   assign wr_sel    = write_en && hit;
   assign push_req  = wr_sel && (offset == 2'd0);
   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign busy      = (state != IDLE);
   assign last_baud = (baud_cnt == 16'd0);
   // A pop frees a slot on the same edge, so a push into a full FIFO still lands then.
   assign pop       = !empty && ((state == IDLE) || (state == STOP && last_baud));
   assign push_ok   = push_req && (!full || pop);

   logic unused_bits;
   assign unused_bits = &{1'b0, addr[1:0], write_data[31:16]};

   always_comb begin
      read_data = 32'd0;
      if (hit) begin
         case (offset)
            2'd1:    read_data = {27'd0, PARITY_FEATURE, overflow, busy, empty, full};
            2'd2:    read_data = {16'd0, divisor};
            default: read_data = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= write_data[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         divisor  <= DEFAULT_DIV;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push_req && !push_ok)
            overflow <= 1'b1;
         else if (wr_sel && offset == 2'd1 && write_data[3])
            overflow <= 1'b0;
         if (wr_sel && offset == 2'd2)
            divisor <= (write_data[15:0] == 16'd0) ? 16'd1 : write_data[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tx       <= 1'b1;
         baud_cnt <= 16'd0;
         bit_cnt  <= 3'd0;
         shreg    <= 8'd0;
         div_lat  <= 16'd1;
`ifdef UART_PARITY_EN
         par_bit  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  shreg    <= fifo_mem[rd_ptr];
                  div_lat  <= divisor;
                  baud_cnt <= divisor - 16'd1;
`ifdef UART_PARITY_EN
                  par_bit  <= ^fifo_mem[rd_ptr];
`endif
                  tx       <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (last_baud) begin
                  baud_cnt <= div_lat - 16'd1;
                  bit_cnt  <= 3'd0;
                  tx       <= shreg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            DATA: begin
               if (last_baud) begin
                  baud_cnt <= div_lat - 16'd1;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                     tx    <= par_bit;
                     state <= PARITY;
`else
                     tx    <= 1'b1;
                     state <= STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     shreg   <= {1'b0, shreg[7:1]};
                     tx      <= shreg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
               if (last_baud) begin
                  baud_cnt <= div_lat - 16'd1;
                  tx       <= 1'b1;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
`endif
            STOP: begin
               if (last_baud) begin
                  // Back-to-back frames: reload straight into START with no idle bit.
                  if (pop) begin
                     shreg    <= fifo_mem[rd_ptr];
                     div_lat  <= divisor;
                     baud_cnt <= divisor - 16'd1;
`ifdef UART_PARITY_EN
                     par_bit  <= ^fifo_mem[rd_ptr];
`endif
                     tx       <= 1'b0;
                     state    <= START;
                  end else begin
                     tx    <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter that responds to the CPU data-port bus (write_en / addr / write_data / read_data), sitting beside data_mem on the same bus. CPU stores to a TX register push bytes into a small FIFO, and a divisor-timed state machine serializes them 8N1 onto a single output line. Status and divisor registers are readable so firmware can poll for space.

## Interface
- BASE_ADDR, 32'h0001_0000: register window base; 16-byte aligned.
- FIFO_DEPTH, 4: TX FIFO entries; power of two, 2..16.
- DEFAULT_DIV, 16'd868: divisor loaded at reset; clocks per bit.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- write_en  input  1  CPU store strobe, sampled at clk rising edge.
- addr  input  32  CPU byte address.
- write_data  input  32  CPU store data.
- read_data  output  32  combinational register read; 0 when not selected.
- hit  output  1  combinational; 1 when addr[31:4] == BASE_ADDR[31:4], used by the CPU writeback mux.
- tx  output  1  serial line, registered, idle high.

## Operation
- Register map, offset = addr[3:2]:
  - 0 TXDATA: write pushes write_data[7:0]; reads 0.
  - 1 STATUS: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky); bits 31:4 read 0. Writing with write_data[3]=1 clears overflow; other bits ignored.
  - 2 DIVISOR: bits 15:0 read/write; a written value of 0 is stored as 1.
  - 3 reserved: writes ignored, reads 0.
- Writes act only when write_en && hit.
- Push to a full FIFO is dropped and sets overflow. Exception: push in the same cycle the FSM pops is accepted, and the count is unchanged.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop a byte into the shift register, latch the divisor, go to START.
  - START: tx=0 for DIV cycles, then DATA.
  - DATA: 8 bits LSB first, DIV cycles each, then STOP.
  - STOP: tx=1 for DIV cycles.
- STOP exit:
  - If the FIFO is non-empty on the last STOP cycle, pop and go directly to START, with no extra idle cycle.
  - Otherwise go to IDLE.
- The divisor is latched per frame. DIVISOR writes mid-frame affect only the next frame.
- Bit counter is 3 bits. The baud counter is 16 bits, counting DIV-1 down to 0.

## Timing
- Reset values:
  - tx=1, FSM=IDLE, FIFO empty (read_data STATUS = 32'h2).
  - overflow=0, divisor=DEFAULT_DIV.
  - read_data/hit remain combinational functions of addr.
- Start-bit latency: push at edge N; FSM pops at edge N+1; tx falls after edge N+1.
- Frame length: 10*DIV cycles. With UART_PARITY_EN: 11*DIV cycles.
- STATUS reflects a push/pop from the edge at which it occurs. Example: empty clears in the cycle after the push edge.
- Reset asserted mid-frame: the next edge forces tx=1, IDLE, and FIFO empty; the partial frame is abandoned.
- read_data has no read side effects. Reads and writes in the same cycle return pre-edge values.

## Configuration
- UART_PARITY_EN defined:
  - adds a PARITY state between DATA and STOP, driving even parity (XOR of the 8 data bits) for DIV cycles;
  - STATUS bit4 reads 1 to advertise the feature.
- Undefined:
  - no PARITY state;
  - STATUS bit4 reads 0;
  - frame is 8N1.

## Test plan
- Reset, then read STATUS and DIVISOR: expect 32'h2 and 868; tx=1 through reset.
- Write DIVISOR=4, then TXDATA=8'hA5: tx goes low one cycle after the push edge and stays low for 4 cycles. Bits sampled mid-bit are 1,0,1,0,0,1,0,1, followed by 4 high stop cycles. Total 40 cycles; busy=0 afterward.
- DIV=2, push 8'h55 and 8'h0F on consecutive edges: the second start bit begins in the cycle right after the first stop's last cycle, with no idle gap.
- DIV=2, push FIFO_DEPTH+1 bytes while the FSM is busy: full=1, the extra byte is dropped, and overflow=1. Write STATUS with bit3=1: overflow=0; transmitted bytes equal the first FIFO_DEPTH+1-1 accepted.
- Write DIVISOR=0: reads back 1. Assert reset mid-DATA: tx=1 the next cycle, and STATUS=32'h2.
- With UART_PARITY_EN and DIV=2, send 8'h07: the parity bit is 1, the frame is 22 cycles, and STATUS bit4=1.
